// File: rtl/secim_sirali_denetleyici.sv
// Serial majority-vote controller: one shared yol_secimi comparator evaluates
// OY_SAYISI votes in turn, tallies the "1" choices and holds the decision until acknowledged.

module yol_secimi (
  input  logic       tasli_yol_uzunlugu,
  input  logic [2:0] asfalt_yol_uzunlugu,
  output logic       secim
);

  // Gravel is four times slower, so one gravel unit weighs as much as four
  // asphalt units; secim = 1 picks asphalt when it is strictly cheaper.
  assign secim = (asfalt_yol_uzunlugu < {tasli_yol_uzunlugu, 2'b00});

endmodule

module secim_sirali_denetleyici #(
  parameter int OY_SAYISI   = 3,
  parameter int ZAMAN_ASIMI = 100
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       oy_gecerli,
  output logic       oy_hazir,
  input  logic       tasli_yol_uzunlugu,
  input  logic [2:0] asfalt_yol_uzunlugu,
  input  logic       iptal,
  input  logic       sonuc_al,
  output logic       sonuc_gecerli,
  output logic       tercih_cogunlugu,
  output logic [2:0] evet_sayisi,
  output logic [2:0] alinan_oy,
  output logic       zaman_asimi
);

  typedef enum logic [1:0] {
    BOS   = 2'd0,
    TOPLA = 2'd1,
    SONUC = 2'd2
  } durum_t;

  localparam logic [2:0]  OY_SON = 3'(OY_SAYISI);
  localparam logic [2:0]  ESIK   = 3'(OY_SAYISI / 2);
  localparam int          ZA_SON_I = (ZAMAN_ASIMI == 0) ? 0 : ZAMAN_ASIMI - 1;
  localparam logic [15:0] ZA_SON = 16'(ZA_SON_I);

  durum_t      durum;
  logic [15:0] bos_sayac;
  logic        secim;
  logic        kabul;
  logic        zaman_doldu;
  logic [2:0]  yeni_alinan;
  logic [2:0]  yeni_evet;

  function automatic logic cogunluk_f(input logic [2:0] evet);
    return (evet > ESIK);
  endfunction

  // Idle counter saturates so a disabled timeout can never wrap it.
  function automatic logic [15:0] sayac_doyur(input logic [15:0] sayac);
    return (sayac == 16'hFFFF) ? sayac : sayac + 16'd1;
  endfunction

  yol_secimi u_yol_secimi (
    .tasli_yol_uzunlugu  (tasli_yol_uzunlugu),
    .asfalt_yol_uzunlugu (asfalt_yol_uzunlugu),
    .secim               (secim)
  );

  assign oy_hazir = (durum != SONUC);

  always_comb begin
    kabul       = oy_gecerli & oy_hazir & ~iptal;
    yeni_alinan = alinan_oy + 3'd1;
    yeni_evet   = evet_sayisi + {2'b00, secim};
    zaman_doldu = (ZAMAN_ASIMI != 0) && (bos_sayac == ZA_SON);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      durum            <= BOS;
      sonuc_gecerli    <= 1'b0;
      tercih_cogunlugu <= 1'b0;
      evet_sayisi      <= 3'd0;
      alinan_oy        <= 3'd0;
      zaman_asimi      <= 1'b0;
      bos_sayac        <= 16'd0;
    end else begin
      zaman_asimi <= 1'b0;
      case (durum)
        BOS, TOPLA: begin
          if (iptal) begin
            // Abort wins over a simultaneous vote and a simultaneous timeout.
            durum       <= BOS;
            alinan_oy   <= 3'd0;
            evet_sayisi <= 3'd0;
            bos_sayac   <= 16'd0;
          end else if (kabul) begin
            alinan_oy   <= yeni_alinan;
            evet_sayisi <= yeni_evet;
            bos_sayac   <= 16'd0;
            if (yeni_alinan == OY_SON) begin
              durum            <= SONUC;
              sonuc_gecerli    <= 1'b1;
              tercih_cogunlugu <= cogunluk_f(yeni_evet);
            end else begin
              durum <= TOPLA;
            end
          end else if (durum == TOPLA) begin
            if (zaman_doldu) begin
              durum       <= BOS;
              alinan_oy   <= 3'd0;
              evet_sayisi <= 3'd0;
              bos_sayac   <= 16'd0;
              zaman_asimi <= 1'b1;
            end else begin
              bos_sayac <= sayac_doyur(bos_sayac);
            end
          end
        end
        SONUC: begin
          if (sonuc_al) begin
            durum         <= BOS;
            sonuc_gecerli <= 1'b0;
            alinan_oy     <= 3'd0;
            evet_sayisi   <= 3'd0;
            bos_sayac     <= 16'd0;
          end
        end
        default: begin
          durum <= BOS;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_secim_sirali_denetleyici.sv
// Directed bench: instance a (3 votes, timeout 4) and instance b (5 votes, timeout off).
// secim = 1 when asfalt < 4*tasli, so (1,0..3) -> 1 and (1,4..7) or (0,x) -> 0.

module tb_secim_sirali_denetleyici;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic       a_gecerli = 1'b0, a_hazir, a_tasli = 1'b0, a_iptal = 1'b0, a_al = 1'b0;
  logic [2:0] a_asfalt = 3'd0;
  logic       a_sonuc, a_tercih, a_zaman;
  logic [2:0] a_evet, a_alinan;

  logic       b_gecerli = 1'b0, b_hazir, b_tasli = 1'b0, b_iptal = 1'b0, b_al = 1'b0;
  logic [2:0] b_asfalt = 3'd0;
  logic       b_sonuc, b_tercih, b_zaman;
  logic [2:0] b_evet, b_alinan;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  secim_sirali_denetleyici #(.OY_SAYISI(3), .ZAMAN_ASIMI(4)) dut_a (
    .clk(clk), .rst(rst), .oy_gecerli(a_gecerli), .oy_hazir(a_hazir),
    .tasli_yol_uzunlugu(a_tasli), .asfalt_yol_uzunlugu(a_asfalt),
    .iptal(a_iptal), .sonuc_al(a_al), .sonuc_gecerli(a_sonuc),
    .tercih_cogunlugu(a_tercih), .evet_sayisi(a_evet), .alinan_oy(a_alinan),
    .zaman_asimi(a_zaman)
  );

  secim_sirali_denetleyici #(.OY_SAYISI(5), .ZAMAN_ASIMI(0)) dut_b (
    .clk(clk), .rst(rst), .oy_gecerli(b_gecerli), .oy_hazir(b_hazir),
    .tasli_yol_uzunlugu(b_tasli), .asfalt_yol_uzunlugu(b_asfalt),
    .iptal(b_iptal), .sonuc_al(b_al), .sonuc_gecerli(b_sonuc),
    .tercih_cogunlugu(b_tercih), .evet_sayisi(b_evet), .alinan_oy(b_alinan),
    .zaman_asimi(b_zaman)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chk3(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic a_oy(input logic t, input logic [2:0] as);
    a_gecerli = 1'b1;
    a_tasli   = t;
    a_asfalt  = as;
  endtask

  task automatic b_oy(input logic t, input logic [2:0] as);
    b_gecerli = 1'b1;
    b_tasli   = t;
    b_asfalt  = as;
  endtask

  task automatic a_reset_state(input string tag);
    chk1({tag, "_hazir"}, a_hazir, 1'b1);
    chk1({tag, "_sonuc"}, a_sonuc, 1'b0);
    chk1({tag, "_tercih"}, a_tercih, 1'b0);
    chk3({tag, "_evet"}, a_evet, 3'd0);
    chk3({tag, "_alinan"}, a_alinan, 3'd0);
    chk1({tag, "_zaman"}, a_zaman, 1'b0);
  endtask

  initial begin
    #1;
    a_reset_state("rst_a");
    chk1("rst_b_hazir", b_hazir, 1'b1);
    chk3("rst_b_alinan", b_alinan, 3'd0);
    step();
    step();
    rst = 1'b0;

    // Round 1: secim 1,1,0 back to back -> majority 1
    a_oy(1'b1, 3'd3);
    step();
    chk3("r1_alinan1", a_alinan, 3'd1);
    chk3("r1_evet1", a_evet, 3'd1);
    chk1("r1_hazir1", a_hazir, 1'b1);
    a_oy(1'b1, 3'd0);
    step();
    chk3("r1_alinan2", a_alinan, 3'd2);
    chk3("r1_evet2", a_evet, 3'd2);
    chk1("r1_sonuc2", a_sonuc, 1'b0);
    a_oy(1'b1, 3'd4);
    step();
    chk1("r1_sonuc", a_sonuc, 1'b1);
    chk1("r1_tercih", a_tercih, 1'b1);
    chk3("r1_evet", a_evet, 3'd2);
    chk3("r1_alinan", a_alinan, 3'd3);
    chk1("r1_hazir", a_hazir, 1'b0);
    step();
    chk3("r1_frozen_alinan", a_alinan, 3'd3);
    chk3("r1_frozen_evet", a_evet, 3'd2);
    a_gecerli = 1'b0;
    a_al = 1'b1;
    step();
    a_al = 1'b0;
    chk1("r1_ack_sonuc", a_sonuc, 1'b0);
    chk3("r1_ack_alinan", a_alinan, 3'd0);
    chk3("r1_ack_evet", a_evet, 3'd0);
    chk1("r1_ack_hazir", a_hazir, 1'b1);
    chk1("r1_ack_tercih_kept", a_tercih, 1'b1);

    // Round 2: secim 0,1,0 -> majority 0, held 5 cycles (iptal ignored meanwhile)
    a_oy(1'b0, 3'd0);
    step();
    a_oy(1'b1, 3'd1);
    step();
    a_oy(1'b1, 3'd7);
    step();
    a_gecerli = 1'b0;
    a_iptal = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk1("r2_hold_sonuc", a_sonuc, 1'b1);
      chk1("r2_hold_tercih", a_tercih, 1'b0);
      chk3("r2_hold_evet", a_evet, 3'd1);
      chk3("r2_hold_alinan", a_alinan, 3'd3);
      step();
    end
    a_iptal = 1'b0;
    chk1("r2_hold_sonuc_last", a_sonuc, 1'b1);
    a_al = 1'b1;
    a_oy(1'b1, 3'd2);
    step();
    a_al = 1'b0;
    chk1("r2_ack_sonuc", a_sonuc, 1'b0);
    chk3("r2_ack_alinan", a_alinan, 3'd0);
    chk3("r2_ack_evet", a_evet, 3'd0);
    chk1("r2_ack_hazir", a_hazir, 1'b1);
    step();
    chk3("r2_next_vote_alinan", a_alinan, 3'd1);
    chk3("r2_next_vote_evet", a_evet, 3'd1);

    // Timeout: one vote taken, then 4 idle cycles
    a_gecerli = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      step();
      chk1("to_idle_zaman", a_zaman, 1'b0);
      chk3("to_idle_alinan", a_alinan, 3'd1);
    end
    step();
    chk1("to_pulse", a_zaman, 1'b1);
    chk3("to_alinan", a_alinan, 3'd0);
    chk3("to_evet", a_evet, 3'd0);
    chk1("to_hazir", a_hazir, 1'b1);
    step();
    chk1("to_pulse_end", a_zaman, 1'b0);

    // iptal together with a 3rd vote
    a_oy(1'b1, 3'd1);
    step();
    a_oy(1'b1, 3'd2);
    step();
    chk3("ip_alinan2", a_alinan, 3'd2);
    a_oy(1'b1, 3'd3);
    a_iptal = 1'b1;
    step();
    a_iptal = 1'b0;
    a_gecerli = 1'b0;
    chk3("ip_alinan", a_alinan, 3'd0);
    chk3("ip_evet", a_evet, 3'd0);
    chk1("ip_sonuc", a_sonuc, 1'b0);
    chk1("ip_zaman", a_zaman, 1'b0);
    for (int i = 0; i < 6; i++) begin
      step();
      chk1("ip_bos_no_timeout", a_zaman, 1'b0);
    end

    // iptal on the cycle the timeout would fire
    a_oy(1'b0, 3'd0);
    step();
    a_gecerli = 1'b0;
    step();
    step();
    step();
    a_iptal = 1'b1;
    step();
    a_iptal = 1'b0;
    chk1("ip_to_no_pulse", a_zaman, 1'b0);
    chk3("ip_to_alinan", a_alinan, 3'd0);

    // Asynchronous reset while holding a result
    a_oy(1'b1, 3'd0);
    step();
    step();
    step();
    a_gecerli = 1'b0;
    chk1("ar_pre_sonuc", a_sonuc, 1'b1);
    chk3("ar_pre_evet", a_evet, 3'd3);
    #2;
    rst = 1'b1;
    #1;
    a_reset_state("ar");
    rst = 1'b0;
    step();

    // Instance b, 5 votes: 1,0,1,0,1 -> majority 1
    b_oy(1'b1, 3'd0); step();
    b_oy(1'b0, 3'd1); step();
    b_oy(1'b1, 3'd3); step();
    b_oy(1'b1, 3'd5); step();
    chk3("b1_alinan4", b_alinan, 3'd4);
    chk1("b1_sonuc4", b_sonuc, 1'b0);
    b_oy(1'b1, 3'd1); step();
    b_gecerli = 1'b0;
    chk1("b1_sonuc", b_sonuc, 1'b1);
    chk1("b1_tercih", b_tercih, 1'b1);
    chk3("b1_evet", b_evet, 3'd3);
    chk3("b1_alinan", b_alinan, 3'd5);
    b_al = 1'b1;
    step();
    b_al = 1'b0;
    chk1("b1_ack_sonuc", b_sonuc, 1'b0);

    // Instance b: 1,0,0,0,1 -> majority 0
    b_oy(1'b1, 3'd2); step();
    b_oy(1'b0, 3'd7); step();
    b_oy(1'b1, 3'd4); step();
    b_oy(1'b1, 3'd6); step();
    b_oy(1'b1, 3'd3); step();
    b_gecerli = 1'b0;
    chk1("b2_sonuc", b_sonuc, 1'b1);
    chk1("b2_tercih", b_tercih, 1'b0);
    chk3("b2_evet", b_evet, 3'd2);
    b_al = 1'b1;
    step();
    b_al = 1'b0;

    // Instance b: timeout disabled, long idle keeps the partial round
    b_oy(1'b1, 3'd0); step();
    b_gecerli = 1'b0;
    for (int i = 0; i < 70; i++) begin
      step();
      if (b_zaman !== 1'b0) chk1("b_no_timeout_pulse", b_zaman, 1'b0);
    end
    chk1("b_no_timeout_zaman", b_zaman, 1'b0);
    chk3("b_no_timeout_alinan", b_alinan, 3'd1);
    chk3("b_no_timeout_evet", b_evet, 3'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/secim_sirali_denetleyici.md
Name: secim_sirali_denetleyici

Overview:
- Serial majority-vote controller that shares a single `yol_secimi` road-choice unit among OY_SAYISI voters.
- Voters present their road lengths one per handshake. The block evaluates each vote through the shared `yol_secimi` instance and tallies the "1" preferences.
- After the last vote it reports the majority decision (`tercih_cogunlugu`) and holds it until acknowledged.
- It replaces N parallel `yol_secimi` instances plus fixed AND/OR majority logic with one comparator and a sequencer.

Parameters:
- OY_SAYISI, 3, number of votes per round; odd, range 3..7.
- ZAMAN_ASIMI, 100, idle cycles allowed between votes inside a round before abort; 0 disables timeout; range 0..65535.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- oy_gecerli  input  1  vote valid.
- oy_hazir  output  1  ready to accept a vote.
- tasli_yol_uzunlugu  input  1  gravel road length of the presented vote.
- asfalt_yol_uzunlugu  input  3  asphalt road length of the presented vote.
- iptal  input  1  abort the current round.
- sonuc_al  input  1  result acknowledge.
- sonuc_gecerli  output  1  result valid, held until acknowledged.
- tercih_cogunlugu  output  1  majority decision.
- evet_sayisi  output  3  running count of votes whose `yol_secimi` output = 1.
- alinan_oy  output  3  votes accepted in the current round.
- zaman_asimi  output  1  one-cycle pulse on timeout abort.

Behaviour:
- Reset values:
  - state = BOS; oy_hazir = 1.
  - sonuc_gecerli, tercih_cogunlugu, evet_sayisi, alinan_oy and zaman_asimi = 0.
  - Idle counter = 0.
- Structure:
  - One `yol_secimi` instance, driven combinationally from `tasli_yol_uzunlugu` and `asfalt_yol_uzunlugu`. Its output is called `secim`.
  - All outputs are registered, except `oy_hazir`, which is decoded from state.
- Acceptance: a vote is accepted on the rising edge where `oy_gecerli` = 1 and `oy_hazir` = 1.
  - On acceptance, `alinan_oy` += 1 and `evet_sayisi` += `secim`.
  - The voter must hold the inputs stable while `oy_gecerli` = 1 and `oy_hazir` = 0.
- States:
  - BOS: `oy_hazir` = 1, counts = 0.
    - Accepted vote → TOPLA.
    - If OY_SAYISI votes are reached on that edge (impossible for OY_SAYISI ≥ 3), go → SONUC instead.
  - TOPLA: `oy_hazir` = 1.
    - An accepted vote that makes `alinan_oy` = OY_SAYISI → SONUC.
    - On that same edge, `tercih_cogunlugu` <= (new `evet_sayisi` > OY_SAYISI/2, integer division) and `sonuc_gecerli` <= 1.
    - Latency: result visible one cycle after the final acceptance edge.
  - SONUC: `oy_hazir` = 0; `sonuc_gecerli` = 1; `tercih_cogunlugu`, `evet_sayisi` and `alinan_oy` are frozen.
    - `sonuc_al` = 1 → BOS: `sonuc_gecerli` <= 0, counts <= 0.
    - `tercih_cogunlugu` keeps its value until the next result.
    - Votes offered in the acknowledge cycle are not accepted; they are accepted earliest in the following cycle.
- Timeout:
  - The idle counter counts cycles in TOPLA with no accepted vote, and clears on each acceptance.
  - When it reaches ZAMAN_ASIMI (ZAMAN_ASIMI ≠ 0): go → BOS, clear counts, pulse `zaman_asimi` = 1 for one cycle.
  - No timeout in BOS or SONUC.
- `iptal`:
  - In BOS or TOPLA: → BOS and clear counts next edge; no `zaman_asimi` pulse.
  - `iptal` has priority over a simultaneous vote (the vote is discarded) and over a simultaneous timeout (no pulse).
  - `iptal` is ignored in SONUC; the result must be acknowledged.
- Asynchronous reset mid-round or mid-result: immediately return to reset values; any partial round is lost.
- Counters are sized so they never wrap: `alinan_oy` ≤ OY_SAYISI ≤ 7 fits in 3 bits; the idle counter is 16 bits.

Test Plan:
- Votes with `secim` = 1,1,0 presented back-to-back with `oy_gecerli` held high → `alinan_oy` reaches 3; one cycle after the 3rd acceptance, `sonuc_gecerli` = 1, `tercih_cogunlugu` = 1, `evet_sayisi` = 2, `oy_hazir` = 0.
- Votes with `secim` = 0,1,0, with `sonuc_al` kept low for 5 cycles and then pulsed → result held with `tercih_cogunlugu` = 0 and `evet_sayisi` = 1 for all 5 cycles; after the ack, `sonuc_gecerli` = 0, counts = 0, `oy_hazir` = 1.
- ZAMAN_ASIMI = 4: one vote, then idle → exactly 4 idle cycles later `zaman_asimi` pulses once; state is BOS with `alinan_oy` = 0.
- Two votes, then `iptal` asserted together with a 3rd `oy_gecerli` → vote dropped, `alinan_oy` = 0, no result, no `zaman_asimi`.
- `rst` asserted asynchronously while in SONUC between edges → outputs go to reset values immediately, without waiting for `clk`.
- OY_SAYISI = 5 with `secim` = 1,0,1,0,1 → `tercih_cogunlugu` = 1, `evet_sayisi` = 3; the same run with `secim` = 1,0,0,0,1 → `tercih_cogunlugu` = 0.
